// File: rtl/gdiv_pkg.sv
// Constants shared by the Goldschmidt divider datapath blocks.
// The operand FIFO, the multiplier and the result FIFO all use these widths.
package gdiv_pkg;

  localparam int unsigned PROD_W = 48;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned FRAC_W = 23;

  localparam logic [MANT_W-1:0] SAT_VAL = 24'hFFFFFF;

endpackage

// File: rtl/mul_round_sat.sv
// Combinational round-half-up and saturate stage.
// It reduces a 2.46 product to a 1.23 mantissa and flags the saturated results.
module mul_round_sat
  import gdiv_pkg::*;
(
  input  logic [PROD_W-1:0] p,
  output logic [MANT_W-1:0] q,
  output logic              sat
);

  logic [MANT_W:0] m;

  // The extra top bit of m catches the carry out of the rounding increment.
  assign m   = {1'b0, p[PROD_W-2:FRAC_W]} + {{MANT_W{1'b0}}, p[FRAC_W-1]};
  assign sat = p[PROD_W-1] | m[MANT_W];
  assign q   = sat ? SAT_VAL : m[MANT_W-1:0];

endmodule

// File: rtl/mul_result_fifo.sv
// Circular product buffer between the 24x24 multiplier and the iteration controller.
// Each pop returns a rounded, saturated 1.23 result one cycle after rd_en.
module mul_result_fifo
  import gdiv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [PROD_W-1:0] product_in,
  input  logic              rd_en,
  output logic [MANT_W-1:0] q_out,
  output logic              q_valid,
  output logic              q_sat,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic [PROD_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [MANT_W-1:0] q_q;
  logic              valid_q, sat_q, ovf_q, unf_q;

  logic              push, pop;
  logic [MANT_W-1:0] head_q;
  logic              head_sat;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
  assign pop  = rd_en & ~empty;
  assign push = wr_en & (~full | pop);

  mul_round_sat u_round (
    .p   (mem[rd_ptr_q]),
    .q   (head_q),
    .sat (head_sat)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= product_in;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        q_q      <= head_q;
        sat_q    <= head_sat;
      end
      if (wr_en && !push) begin
        ovf_q <= 1'b1;
      end
      if (rd_en && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign q_out     = q_q;
  assign q_valid   = valid_q;
  assign q_sat     = sat_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
